regbank_bus_arbiter: RTL and testbench

REGBANK_BUS_ARBITER -- requirements
Module: regbank_bus_arbiter

---
 rtl/regbank_bus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_regbank_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port register bank.
// Optional WAIT-state watchdog enabled by defining REGBANK_ARB_TIMEOUT_EN.
module regbank_bus_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_rd,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_rd_done,
    output logic              m0_wr_done,
    output logic              m0_busy,
    output logic              m0_err,
    input  logic              m1_rd,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_rd_done,
    output logic              m1_wr_done,
    output logic              m1_busy,
    output logic              m1_err,
    output logic              s_rd_mem,
    output logic              s_wr_mem,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    input  logic [31:0]       s_rdata,
    input  logic              s_rd_done,
    input  logic              s_wr_done
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : gen_timeout_range
        $error("TIMEOUT must be within 2..65535");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;

    logic [1:0]              rd_in, wr_in;
    logic [1:0][ADDR_W-1:0]  addr_in;
    logic [1:0][31:0]        wdata_in;

    logic [1:0]              pend_q, pend_d;
    logic [1:0]              op_wr_q, op_wr_d;
    logic [1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0][31:0]        wdata_q, wdata_d;

    logic                    gnt_q, gnt_d;
    logic                    last_q, last_d;
    logic                    gnt_sel;

    logic                    s_rd_mem_q, s_rd_mem_d;
    logic                    s_wr_mem_q, s_wr_mem_d;
    logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
    logic [31:0]             s_wdata_q, s_wdata_d;
    logic [1:0]              rd_done_q, rd_done_d;
    logic [1:0]              wr_done_q, wr_done_d;
    logic [1:0]              err_q, err_d;
    logic [1:0][31:0]        rdata_q, rdata_d;

    logic                    match_done;
    logic                    timed_out;
    logic                    complete;

    assign rd_in    = {m1_rd, m0_rd};
    assign wr_in    = {m1_wr, m0_wr};
    assign addr_in  = {m1_addr, m0_addr};
    assign wdata_in = {m1_wdata, m0_wdata};

    assign match_done = (state_q == StWait) &&
                        (op_wr_q[gnt_q] ? s_wr_done : s_rd_done);
    assign complete   = match_done || timed_out;

`ifdef REGBANK_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign timed_out = (state_q == StWait) && !match_done && (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        cnt_d = 16'd0;
        if (state_q == StWait && !complete) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Both pending: alternate against the last completed grant.
    assign gnt_sel = (&pend_q) ? ~last_q : pend_q[1];

    // Request capture; strobes from a busy master are dropped, write wins over read.
    always_comb begin
        pend_d  = pend_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (complete) begin
            pend_d[gnt_q] = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            if (!pend_q[n] && (rd_in[n] || wr_in[n])) begin
                pend_d[n]  = 1'b1;
                op_wr_d[n] = wr_in[n];
                addr_d[n]  = addr_in[n];
                wdata_d[n] = wdata_in[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|pend_q) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (complete) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; strobe is launched on the IDLE->ISSUE edge.
    always_comb begin
        gnt_d      = gnt_q;
        last_d     = last_q;
        s_rd_mem_d = 1'b0;
        s_wr_mem_d = 1'b0;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        rd_done_d  = 2'b00;
        wr_done_d  = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;
        if (state_q == StIdle && |pend_q) begin
            gnt_d    = gnt_sel;
            s_addr_d = addr_q[gnt_sel];
            if (op_wr_q[gnt_sel]) begin
                s_wr_mem_d = 1'b1;
                s_wdata_d  = wdata_q[gnt_sel];
            end else begin
                s_rd_mem_d = 1'b1;
            end
        end
        if (complete) begin
            last_d       = gnt_q;
            err_d[gnt_q] = timed_out;
            if (op_wr_q[gnt_q]) begin
                wr_done_d[gnt_q] = 1'b1;
            end else begin
                rd_done_d[gnt_q] = 1'b1;
                rdata_d[gnt_q]   = match_done ? s_rdata : 32'hDEADBEEF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= 2'b00;
            op_wr_q    <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            s_rd_mem_q <= 1'b0;
            s_wr_mem_q <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= 32'd0;
            rd_done_q  <= 2'b00;
            wr_done_q  <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            s_rd_mem_q <= s_rd_mem_d;
            s_wr_mem_q <= s_wr_mem_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign m0_rdata   = rdata_q[0];
    assign m1_rdata   = rdata_q[1];
    assign m0_rd_done = rd_done_q[0];
    assign m1_rd_done = rd_done_q[1];
    assign m0_wr_done = wr_done_q[0];
    assign m1_wr_done = wr_done_q[1];
    assign m0_err     = err_q[0];
    assign m1_err     = err_q[1];
    assign m0_busy    = pend_q[0];
    assign m1_busy    = pend_q[1];
    assign s_rd_mem   = s_rd_mem_q;
    assign s_wr_mem   = s_wr_mem_q;
    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;

endmodule

// File: tb/tb_regbank_bus_arbiter.sv
// Scoreboard bench for regbank_bus_arbiter: directed stimulus pushes expected
// slave strobes and master completions; a negedge monitor pops and compares.
module tb_regbank_bus_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [31:0]   m0_wdata = '0, m1_wdata = '0;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          m0_rd_done, m0_wr_done, m0_busy, m0_err;
    logic          m1_rd_done, m1_wr_done, m1_busy, m1_err;
    logic          s_rd_mem, s_wr_mem;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [31:0]   s_rdata = '0;
    logic          s_rd_done = 1'b0, s_wr_done = 1'b0;

    regbank_bus_arbiter #(.ADDR_W(AW), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_rd_done(m0_rd_done), .m0_wr_done(m0_wr_done),
        .m0_busy(m0_busy), .m0_err(m0_err),
        .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_rd_done(m1_rd_done), .m1_wr_done(m1_wr_done),
        .m1_busy(m1_busy), .m1_err(m1_err),
        .s_rd_mem(s_rd_mem), .s_wr_mem(s_wr_mem), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_rd_done(s_rd_done), .s_wr_done(s_wr_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 s_rd_mem, 1 s_wr_mem, 2 m0_rd_done, 3 m0_wr_done,
    // 4 m1_rd_done, 5 m1_wr_done, 9 err without done (never expected).
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(string name, logic [159:0] act, logic [159:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(int kind, int c, logic [31:0] a, logic [31:0] d, logic e);
        ev_t x;
        x = '{kind: kind, cyc: c, addr: a, data: d, err: e};
        exp_q.push_back(x);
    endtask

    task automatic observe(int kind, logic [31:0] a, logic [31:0] d, logic e);
        ev_t x;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            x = exp_q.pop_front();
            chk($sformatf("event_kind%0d_cyc%0d", x.kind, x.cyc),
                {32'(kind), 32'(cyc), a, d, 31'd0, e},
                {32'(x.kind), 32'(x.cyc), x.addr, x.data, 31'd0, x.err});
        end
    endtask

    always @(negedge clk) begin
        if (s_rd_mem)   observe(0, 32'(s_addr), 32'd0, 1'b0);
        if (s_wr_mem)   observe(1, 32'(s_addr), s_wdata, 1'b0);
        if (m0_rd_done) observe(2, 32'd0, m0_rdata, m0_err);
        if (m0_wr_done) observe(3, 32'd0, 32'd0, m0_err);
        if (m1_rd_done) observe(4, 32'd0, m1_rdata, m1_err);
        if (m1_wr_done) observe(5, 32'd0, 32'd0, m1_err);
        if ((m0_err && !m0_rd_done && !m0_wr_done) || (m1_err && !m1_rd_done && !m1_wr_done))
            observe(9, 32'd0, 32'd0, 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    // Both masters write in the same cycle; 'first' is the master expected to win.
    task automatic run_pair(bit first);
        int t;
        t = cyc;
        m0_wr = 1'b1; m0_addr = 8'h01; m0_wdata = 32'h12;
        m1_wr = 1'b1; m1_addr = 8'h02; m1_wdata = 32'h34;
        expect_ev(1, t + 2, first ? 32'h02 : 32'h01, first ? 32'h34 : 32'h12, 1'b0);
        tick();
        m0_wr = 1'b0; m1_wr = 1'b0;
        ticks(2);
        s_wr_done = 1'b1;
        expect_ev(first ? 5 : 3, t + 4, 32'd0, 32'd0, 1'b0);
        expect_ev(1, t + 5, first ? 32'h01 : 32'h02, first ? 32'h12 : 32'h34, 1'b0);
        tick();
        s_wr_done = 1'b0;
        ticks(2);
        s_wr_done = 1'b1;
        expect_ev(first ? 3 : 5, t + 7, 32'd0, 32'd0, 1'b0);
        tick();
        s_wr_done = 1'b0;
        ticks(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish within time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        ticks(3);
        chk("reset_outputs",
            {m0_rdata, m1_rdata, s_addr, s_wdata, m0_rd_done, m0_wr_done, m0_busy, m0_err,
             m1_rd_done, m1_wr_done, m1_busy, m1_err, s_rd_mem, s_wr_mem}, 160'd0);
        rst_n = 1'b1;
        tick();

        // Uncontended read: strobe T, slave strobe T+2, slave done T+4, master done T+5.
        t = cyc;
        m0_rd = 1'b1; m0_addr = 8'h05;
        expect_ev(0, t + 2, 32'h05, 32'd0, 1'b0);
        chk("m0_busy_before", m0_busy, 1'b0);
        tick();
        m0_rd = 1'b0;
        chk("m0_busy_rise", m0_busy, 1'b1);
        ticks(3);
        s_rd_done = 1'b1; s_rdata = 32'h000000A5;
        expect_ev(2, t + 5, 32'd0, 32'hA5, 1'b0);
        tick();
        s_rd_done = 1'b0; s_rdata = 32'd0;
        chk("m0_busy_clear", m0_busy, 1'b0);
        ticks(2);
        chk("m0_rdata_held", m0_rdata, 32'hA5);

        // After the read above m0 was last, so a same-cycle pair goes m1 first;
        // reset the history to prove m0 wins right after reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_pair(1'b0);
        run_pair(1'b0);

        // A lone m0 write makes m0 the last grant, so the repeated pair starts with m1.
        t = cyc;
        m0_wr = 1'b1; m0_addr = 8'h03; m0_wdata = 32'h56;
        expect_ev(1, t + 2, 32'h03, 32'h56, 1'b0);
        tick();
        m0_wr = 1'b0;
        ticks(2);
        s_wr_done = 1'b1;
        expect_ev(3, t + 4, 32'd0, 32'd0, 1'b0);
        tick();
        s_wr_done = 1'b0;
        ticks(2);
        run_pair(1'b1);

        // Second m1 read while busy is dropped.
        t = cyc;
        m1_rd = 1'b1; m1_addr = 8'h10;
        expect_ev(0, t + 2, 32'h10, 32'd0, 1'b0);
        tick();
        m1_addr = 8'h20;
        tick();
        m1_rd = 1'b0;
        tick();
        s_rd_done = 1'b1; s_rdata = 32'hCAFE0034;
        expect_ev(4, t + 4, 32'd0, 32'hCAFE0034, 1'b0);
        tick();
        s_rd_done = 1'b0; s_rdata = 32'd0;
        chk("m0_rdata_untouched", m0_rdata, 32'd0);
        ticks(4);

        // Write-done during a pending read is ignored.
        t = cyc;
        m0_rd = 1'b1; m0_addr = 8'h07;
        expect_ev(0, t + 2, 32'h07, 32'd0, 1'b0);
        tick();
        m0_rd = 1'b0;
        ticks(2);
        s_wr_done = 1'b1;
        tick();
        s_wr_done = 1'b0;
        chk("m0_busy_after_wrong_done", m0_busy, 1'b1);
        tick();
        s_rd_done = 1'b1; s_rdata = 32'h12345678;
        expect_ev(2, t + 6, 32'd0, 32'h12345678, 1'b0);
        tick();
        s_rd_done = 1'b0; s_rdata = 32'd0;
        ticks(2);

`ifdef REGBANK_ARB_TIMEOUT_EN
        // Silent slave: forced completion 16 cycles after entering WAIT (T+3).
        t = cyc;
        m0_rd = 1'b1; m0_addr = 8'h09;
        expect_ev(0, t + 2, 32'h09, 32'd0, 1'b0);
        expect_ev(2, t + 19, 32'd0, 32'hDEADBEEF, 1'b1);
        tick();
        m0_rd = 1'b0;
        ticks(19);
        chk("m0_busy_after_timeout", m0_busy, 1'b0);
`else
        // Without the watchdog a slow slave is simply waited for.
        t = cyc;
        m0_rd = 1'b1; m0_addr = 8'h09;
        expect_ev(0, t + 2, 32'h09, 32'd0, 1'b0);
        tick();
        m0_rd = 1'b0;
        ticks(22);
        chk("m0_busy_slow_slave", m0_busy, 1'b1);
        s_rd_done = 1'b1; s_rdata = 32'h0BAD0001;
        expect_ev(2, t + 24, 32'd0, 32'h0BAD0001, 1'b0);
        tick();
        s_rd_done = 1'b0; s_rdata = 32'd0;
        ticks(2);
`endif
        t = cyc;
        m1_wr = 1'b1; m1_addr = 8'h04; m1_wdata = 32'h77;
        expect_ev(1, t + 2, 32'h04, 32'h77, 1'b0);
        tick();
        m1_wr = 1'b0;
        ticks(2);
        s_wr_done = 1'b1;
        expect_ev(5, t + 4, 32'd0, 32'd0, 1'b0);
        tick();
        s_wr_done = 1'b0;
        ticks(2);

        // Reset during WAIT aborts silently; the late slave done is ignored.
        t = cyc;
        m1_wr = 1'b1; m1_addr = 8'h03; m1_wdata = 32'h55;
        expect_ev(1, t + 2, 32'h03, 32'h55, 1'b0);
        tick();
        m1_wr = 1'b0;
        ticks(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        s_wr_done = 1'b1;
        tick();
        s_wr_done = 1'b0;
        chk("m1_busy_after_reset", m1_busy, 1'b0);
        chk("m1_rdata_after_reset", m1_rdata, 32'd0);
        ticks(2);
        t = cyc;
        m0_rd = 1'b1; m0_addr = 8'h0A;
        expect_ev(0, t + 2, 32'h0A, 32'd0, 1'b0);
        tick();
        m0_rd = 1'b0;
        ticks(2);
        s_rd_done = 1'b1; s_rdata = 32'hBB;
        expect_ev(2, t + 4, 32'd0, 32'hBB, 1'b0);
        tick();
        s_rd_done = 1'b0; s_rdata = 32'd0;
        ticks(5);

        chk("scoreboard_drained", 160'(exp_q.size()), 160'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
